// File: rtl/wave_disp_pkg.sv
// wave_disp_pkg: shared FSM state, channel-index width helper and sample-to-Y mapping
package wave_disp_pkg;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, NEXT_CH, DONE} rd_state_t;

    function automatic int ch_width(input int ch_num);
        return $clog2(ch_num) + 1;
    endfunction

    // Larger codes draw higher on screen (smaller Y); result is clamped to the visible area
    function automatic int y_map(input int data, input int mid, input logic [1:0] gain,
                                 input int offset, input int center, input int screen_h);
        int y;
        y = center - ((data - mid) <<< gain) + offset;
        return (y < 0) ? 0 : (y > screen_h - 1) ? screen_h - 1 : y;
    endfunction

endpackage

// File: rtl/wave_y_scale.sv
// wave_y_scale: registered sample-to-Y mapping plus min/max segment against the previous point
module wave_y_scale
    import wave_disp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 9,
    parameter int Y_W      = 11,
    parameter int SCREEN_H = 720,
    parameter int Y_CENTER = 360,
    parameter int CH_W     = 2
) (
    input  logic              ram_rd_clk,
    input  logic              rstn,
    input  logic              smp_vld,
    input  logic [CH_W-1:0]   smp_ch,
    input  logic [ADDR_W:0]   smp_x,
    input  logic [DATA_W-1:0] smp_data,
    input  logic [1:0]        smp_gain,
    input  logic [Y_W-1:0]    smp_off,
    output logic              pt_valid,
    output logic [CH_W-1:0]   pt_ch,
    output logic [ADDR_W:0]   pt_x,
    output logic [Y_W-1:0]    pt_y_lo,
    output logic [Y_W-1:0]    pt_y_hi
);

    logic [Y_W-1:0] y, prev_y;
    logic           first;

    assign y = Y_W'(y_map(int'(smp_data), 2 ** (DATA_W - 1), smp_gain,
                          int'($signed(smp_off)), Y_CENTER, SCREEN_H));
    // x==0 starts a new trace, so the stale previous Y of another channel is ignored
    assign first = (smp_x == '0);

    always_ff @(posedge ram_rd_clk) begin
        if (!rstn) begin
            pt_valid <= 1'b0;
            pt_ch    <= '0;
            pt_x     <= '0;
            pt_y_lo  <= '0;
            pt_y_hi  <= '0;
            prev_y   <= '0;
        end else begin
            pt_valid <= smp_vld;
            if (smp_vld) begin
                pt_ch   <= smp_ch;
                pt_x    <= smp_x;
                pt_y_lo <= (first || y < prev_y) ? y : prev_y;
                pt_y_hi <= (first || y > prev_y) ? y : prev_y;
                prev_y  <= y;
            end
        end
    end

endmodule

// File: rtl/wave_multi_rd_ctrl.sv
// wave_multi_rd_ctrl: per-frame multi-channel capture RAM reader producing Y line segments
module wave_multi_rd_ctrl
    import wave_disp_pkg::*;
#(
    parameter int CH_NUM      = 2,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 9,
    parameter int DISP_POINTS = 300,
    parameter int RD_LAT      = 1,
    parameter int Y_W         = 11,
    parameter int SCREEN_H    = 720,
    parameter int Y_CENTER    = 360,
    localparam int CH_W       = ch_width(CH_NUM)
) (
    input  logic                     ram_rd_clk,
    input  logic                     rstn,
    input  logic                     frame_start,
    input  logic                     wave_ready,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic [ADDR_W-1:0]        rd_base,
    input  logic [2*CH_NUM-1:0]      v_gain,
    input  logic [Y_W*CH_NUM-1:0]    v_offset,
    output logic                     ram_rd_en,
    output logic [ADDR_W-1:0]        wave_rd_addr,
    output logic [CH_W-1:0]          wave_rd_ch,
    input  logic [DATA_W*CH_NUM-1:0] wave_rd_data,
    output logic                     ram_rd_over,
    output logic                     pt_valid,
    output logic [CH_W-1:0]          pt_ch,
    output logic [ADDR_W:0]          pt_x,
    output logic [Y_W-1:0]           pt_y_lo,
    output logic [Y_W-1:0]           pt_y_hi,
    output logic                     busy,
    output logic                     frame_skip
);

    localparam int PW = 1 + CH_W + ADDR_W + 1;

    rd_state_t             state;
    logic [CH_NUM-1:0]     en_l;
    logic [ADDR_W-1:0]     base_l;
    logic [2*CH_NUM-1:0]   gain_l;
    logic [Y_W*CH_NUM-1:0] off_l;
    logic [ADDR_W:0]       cnt;
    logic [1:0]            dcnt;
    logic [CH_NUM-1:0]     srch_mask;
    logic [CH_W-1:0]       srch_from, nxt_ch;
    logic                  nxt_ok;
    logic [PW-1:0]         p1, p2, pd;
    logic                  pd_vld;
    logic [CH_W-1:0]       pd_ch;
    logic [ADDR_W:0]       pd_x;

    // In IDLE search the live enables from channel 0, otherwise the latched ones above the current channel
    assign srch_mask = (state == IDLE) ? ch_en : en_l;
    assign srch_from = (state == IDLE) ? '0 : wave_rd_ch + CH_W'(1);

    always_comb begin
        nxt_ch = '0;
        nxt_ok = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (srch_mask[i] && i >= int'(srch_from)) begin
                nxt_ch = CH_W'(i);
                nxt_ok = 1'b1;
            end
    end

    always_ff @(posedge ram_rd_clk) begin
        if (!rstn) begin
            state        <= IDLE;
            ram_rd_en    <= 1'b0;
            wave_rd_addr <= '0;
            wave_rd_ch   <= '0;
            ram_rd_over  <= 1'b0;
            busy         <= 1'b0;
            frame_skip   <= 1'b0;
            en_l         <= '0;
            base_l       <= '0;
            gain_l       <= '0;
            off_l        <= '0;
            cnt          <= '0;
            dcnt         <= '0;
        end else begin
            ram_rd_over <= 1'b0;
            frame_skip  <= frame_start && (state != IDLE || !wave_ready);
            case (state)
                IDLE: if (frame_start && wave_ready) begin
                    en_l         <= ch_en;
                    base_l       <= rd_base;
                    gain_l       <= v_gain;
                    off_l        <= v_offset;
                    busy         <= nxt_ok;
                    ram_rd_over  <= !nxt_ok;
                    ram_rd_en    <= nxt_ok;
                    wave_rd_addr <= rd_base;
                    wave_rd_ch   <= nxt_ch;
                    cnt          <= '0;
                    state        <= nxt_ok ? READ : DONE;
                end
                READ: if (cnt == (ADDR_W + 1)'(DISP_POINTS - 1)) begin
                    ram_rd_en <= 1'b0;
                    dcnt      <= '0;
                    state     <= DRAIN;
                end else begin
                    cnt          <= cnt + 1'b1;
                    wave_rd_addr <= wave_rd_addr + 1'b1;
                end
                DRAIN: if (dcnt == 2'(RD_LAT)) state <= NEXT_CH;
                       else dcnt <= dcnt + 1'b1;
                NEXT_CH: if (nxt_ok) begin
                    ram_rd_en    <= 1'b1;
                    wave_rd_addr <= base_l;
                    wave_rd_ch   <= nxt_ch;
                    cnt          <= '0;
                    state        <= READ;
                end else begin
                    ram_rd_over <= 1'b1;
                    busy        <= 1'b0;
                    state       <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Carry the read tag alongside the RAM latency so it meets its data
    always_ff @(posedge ram_rd_clk) begin
        if (!rstn) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= {ram_rd_en, wave_rd_ch, cnt};
            p2 <= p1;
        end
    end

    assign pd = (RD_LAT == 2) ? p2 : p1;
    assign {pd_vld, pd_ch, pd_x} = pd;

    wave_y_scale #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .Y_W      (Y_W),
        .SCREEN_H (SCREEN_H),
        .Y_CENTER (Y_CENTER),
        .CH_W     (CH_W)
    ) u_scale (
        .ram_rd_clk (ram_rd_clk),
        .rstn       (rstn),
        .smp_vld    (pd_vld),
        .smp_ch     (pd_ch),
        .smp_x      (pd_x),
        .smp_data   (wave_rd_data[pd_ch*DATA_W +: DATA_W]),
        .smp_gain   (gain_l[pd_ch*2 +: 2]),
        .smp_off    (off_l[pd_ch*Y_W +: Y_W]),
        .pt_valid   (pt_valid),
        .pt_ch      (pt_ch),
        .pt_x       (pt_x),
        .pt_y_lo    (pt_y_lo),
        .pt_y_hi    (pt_y_hi)
    );

endmodule

// File: tb/tb_wave_multi_rd_ctrl.sv
// tb_wave_multi_rd_ctrl: scoreboard bench for the multi-channel waveform reader
module tb_wave_multi_rd_ctrl;

    localparam int NP = 300;

    logic        ram_rd_clk = 0, rstn = 0, frame_start = 0, wave_ready = 0;
    logic [1:0]  ch_en = 0;
    logic [8:0]  rd_base = 0;
    logic [3:0]  v_gain = 0;
    logic [21:0] v_offset = 0;
    logic        ram_rd_en, ram_rd_over, pt_valid, busy, frame_skip;
    logic [8:0]  wave_rd_addr;
    logic [1:0]  wave_rd_ch, pt_ch;
    logic [15:0] wave_rd_data = 0;
    logic [9:0]  pt_x;
    logic [10:0] pt_y_lo, pt_y_hi;
    logic [49:0] outs;

    logic [7:0] mem [2][512];
    int  checks = 0, failures = 0, cyc = 0, last_pt_cyc = 0, ea;
    bit  sb_on = 0;

    typedef struct {int ch; int x; int lo; int hi;} pt_t;
    pt_t pt_q[$];
    pt_t ep;
    int  addr_q[$];

    wave_multi_rd_ctrl dut (
        .ram_rd_clk   (ram_rd_clk),
        .rstn         (rstn),
        .frame_start  (frame_start),
        .wave_ready   (wave_ready),
        .ch_en        (ch_en),
        .rd_base      (rd_base),
        .v_gain       (v_gain),
        .v_offset     (v_offset),
        .ram_rd_en    (ram_rd_en),
        .wave_rd_addr (wave_rd_addr),
        .wave_rd_ch   (wave_rd_ch),
        .wave_rd_data (wave_rd_data),
        .ram_rd_over  (ram_rd_over),
        .pt_valid     (pt_valid),
        .pt_ch        (pt_ch),
        .pt_x         (pt_x),
        .pt_y_lo      (pt_y_lo),
        .pt_y_hi      (pt_y_hi),
        .busy         (busy),
        .frame_skip   (frame_skip)
    );

    assign outs = {ram_rd_en, wave_rd_addr, wave_rd_ch, ram_rd_over, pt_valid, pt_ch, pt_x,
                   pt_y_lo, pt_y_hi, busy, frame_skip};

    always #5 ram_rd_clk = ~ram_rd_clk;

    // Capture RAMs with one cycle of read latency, both channels read at the same address
    always @(posedge ram_rd_clk) begin
        cyc <= cyc + 1;
        if (ram_rd_en) wave_rd_data <= {mem[1][wave_rd_addr], mem[0][wave_rd_addr]};
    end

    function automatic int model_y(int d, int g, int off);
        int y;
        y = 360 - (d - 128) * (1 << g) + off;
        return y < 0 ? 0 : y > 719 ? 719 : y;
    endfunction

    task automatic push_frame(input logic [1:0] en, input int base, input int g0, input int g1,
                              input int o0, input int o1);
        int a, y, prev;
        pt_t p;
        ch_en    = en;
        rd_base  = base[8:0];
        v_gain   = {g1[1:0], g0[1:0]};
        v_offset = {o1[10:0], o0[10:0]};
        for (int c = 0; c < 2; c++) if (en[c]) begin
            prev = 0;
            for (int x = 0; x < NP; x++) begin
                a = (base + x) % 512;
                y = model_y(int'(mem[c][a]), c ? g1 : g0, c ? o1 : o0);
                addr_q.push_back(c * 1024 + a);
                p.ch = c;
                p.x  = x;
                p.lo = (x == 0 || y < prev) ? y : prev;
                p.hi = (x == 0 || y > prev) ? y : prev;
                pt_q.push_back(p);
                prev = y;
            end
        end
    endtask

    task automatic pulse_fs();
        @(posedge ram_rd_clk); #1 frame_start = 1;
        @(posedge ram_rd_clk); #1 frame_start = 0;
    endtask

    task automatic wait_over(output bit seen);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge ram_rd_clk);
            seen = ram_rd_over;
        end
    endtask

    always @(negedge ram_rd_clk) if (sb_on) begin
        if (ram_rd_en) begin
            checks++;
            if (addr_q.size() == 0) begin
                failures++;
                $display("FAIL rd_extra: ch=%0d addr=%0d but no read expected", wave_rd_ch, wave_rd_addr);
            end else begin
                ea = addr_q.pop_front();
                if (int'(wave_rd_ch) * 1024 + int'(wave_rd_addr) !== ea) begin
                    failures++;
                    $display("FAIL rd_addr: got ch=%0d addr=%0d exp ch=%0d addr=%0d",
                             wave_rd_ch, wave_rd_addr, ea / 1024, ea % 1024);
                end
            end
        end
        if (pt_valid) begin
            checks++;
            last_pt_cyc = cyc;
            if (pt_q.size() == 0) begin
                failures++;
                $display("FAIL pt_extra: ch=%0d x=%0d but no point expected", pt_ch, pt_x);
            end else begin
                ep = pt_q.pop_front();
                if (int'(pt_ch) !== ep.ch || int'(pt_x) !== ep.x || int'(pt_y_lo) !== ep.lo || int'(pt_y_hi) !== ep.hi) begin
                    failures++;
                    $display("FAIL pt: got ch=%0d x=%0d lo=%0d hi=%0d exp ch=%0d x=%0d lo=%0d hi=%0d",
                             pt_ch, pt_x, pt_y_lo, pt_y_hi, ep.ch, ep.x, ep.lo, ep.hi);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge ram_rd_clk);
        #1 checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h exp 0", outs);
        end
        rstn = 1;
        wave_ready = 1;
        sb_on = 1;
    endtask

    task automatic test_const();
        bit seen;
        for (int a = 0; a < 512; a++) begin mem[0][a] = 128; mem[1][a] = 128; end
        push_frame(2'b01, 0, 0, 0, 0, 0);
        pulse_fs();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL const_busy: got %0b exp 1", busy); end
        wait_over(seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL const_over: no ram_rd_over within bound"); end
        checks++;
        if (pt_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL const_left: %0d points %0d reads not seen, exp 0", pt_q.size(), addr_q.size());
        end
        checks++;
        if (cyc - last_pt_cyc < 1 || cyc - last_pt_cyc > 2) begin
            failures++;
            $display("FAIL const_over_timing: over %0d cycles after last point, exp 1..2", cyc - last_pt_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL const_busy_end: got %0b exp 0", busy); end
        @(negedge ram_rd_clk);
        checks++;
        if (ram_rd_over !== 1'b0) begin failures++; $display("FAIL const_over_width: got %0b exp 0", ram_rd_over); end
        pt_q.delete();
        addr_q.delete();
    endtask

    task automatic run_checked(input string name);
        bit seen;
        pulse_fs();
        wait_over(seen);
        checks++;
        if (!seen || pt_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL %s_done: over=%0b points_left=%0d reads_left=%0d exp 1/0/0",
                     name, seen, pt_q.size(), addr_q.size());
        end
        pt_q.delete();
        addr_q.delete();
    endtask

    task automatic test_ramp();
        for (int a = 0; a < 512; a++) begin mem[0][a] = 8'(a); mem[1][a] = 8'(a); end
        push_frame(2'b11, 0, 1, 1, 0, 100);
        run_checked("ramp");
    endtask

    task automatic test_clamp();
        for (int a = 0; a < 512; a++) begin mem[0][a] = 0; mem[1][a] = 255; end
        push_frame(2'b11, 0, 3, 3, 0, -500);
        run_checked("clamp");
    endtask

    task automatic test_step();
        for (int a = 0; a < 512; a++) mem[0][a] = (a < 10) ? 8'd100 : 8'd200;
        push_frame(2'b01, 0, 0, 0, 0, 0);
        run_checked("step");
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 512; a++) begin mem[0][a] = 8'($urandom); mem[1][a] = 8'($urandom); end
        push_frame(2'b11, 400, 2, 0, -40, 25);
        run_checked("wrap");
    endtask

    task automatic test_not_ready();
        int rd;
        wave_ready = 0;
        ch_en = 2'b11;
        pulse_fs();
        checks++;
        if (frame_skip !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL notready_skip: got skip=%0b busy=%0b exp 1/0", frame_skip, busy);
        end
        rd = 0;
        repeat (10) begin @(posedge ram_rd_clk); #1 rd += int'(ram_rd_en); end
        checks++;
        if (rd != 0) begin failures++; $display("FAIL notready_reads: got %0d reads exp 0", rd); end
        wave_ready = 1;
    endtask

    task automatic test_skip_busy();
        for (int a = 0; a < 512; a++) mem[1][a] = 8'(a * 3);
        push_frame(2'b10, 37, 1, 1, 0, -60);
        pulse_fs();
        repeat (20) @(posedge ram_rd_clk);
        pulse_fs();
        checks++;
        if (frame_skip !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_skip: got skip=%0b busy=%0b exp 1/1", frame_skip, busy);
        end
        begin
            bit seen;
            wait_over(seen);
            checks++;
            if (!seen || pt_q.size() != 0 || addr_q.size() != 0) begin
                failures++;
                $display("FAIL busy_done: over=%0b points_left=%0d reads_left=%0d exp 1/0/0",
                         seen, pt_q.size(), addr_q.size());
            end
        end
        pt_q.delete();
        addr_q.delete();
    endtask

    task automatic test_no_channels();
        ch_en = 2'b00;
        pulse_fs();
        checks++;
        if (ram_rd_over !== 1'b1 || ram_rd_en !== 1'b0 || frame_skip !== 1'b0) begin
            failures++;
            $display("FAIL noch_over: got over=%0b rd_en=%0b skip=%0b exp 1/0/0", ram_rd_over, ram_rd_en, frame_skip);
        end
        @(posedge ram_rd_clk); #1 checks++;
        if (ram_rd_over !== 1'b0) begin failures++; $display("FAIL noch_over_width: got %0b exp 0", ram_rd_over); end
    endtask

    task automatic test_abort();
        int ev;
        sb_on = 0;
        ch_en = 2'b11;
        pulse_fs();
        repeat (50) @(posedge ram_rd_clk);
        #1 checks++;
        if (ram_rd_en !== 1'b1) begin failures++; $display("FAIL abort_reading: got rd_en=%0b exp 1", ram_rd_en); end
        rstn = 0;
        @(posedge ram_rd_clk); #1 checks++;
        if (outs !== '0) begin failures++; $display("FAIL abort_outputs: got %h exp 0", outs); end
        rstn = 1;
        ev = 0;
        repeat (700) begin @(posedge ram_rd_clk); #1 ev += int'(ram_rd_over) + int'(pt_valid) + int'(ram_rd_en); end
        checks++;
        if (ev != 0) begin failures++; $display("FAIL abort_quiet: got %0d events exp 0", ev); end
        sb_on = 1;
    endtask

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_clamp();
        test_step();
        test_wrap();
        test_not_ready();
        test_skip_busy();
        test_no_channels();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
